deconv_col_accum: RTL and testbench

Parametrised transposed-convolution column engine, successor to the single-channel column datapath in the deconvolution top level. Each accepted beat multiplies one feature-map column by one weight column and overlap-adds the products at a runtime stride. Results accumulate across a runtime number of input channels, and the completed output column is presented through a valid/ready handshake. It sits between the weight/feature FIFOs and the downstream overlap/row buffer and needs no separate shift register or strobe logic.

---
 rtl/deconv_col_accum.sv | 144 ++++++++++++++
 tb/tb_deconv_col_accum.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/deconv_col_accum.sv
// Transposed-convolution column engine: one feature column x one weight column per beat, overlap-added at stride S and saturating-accumulated over C channels.
// The result is valid 1 cycle after the last beat and held (o_ready=0) until the consumer takes it; one dead cycle per group.
module deconv_col_accum #(
  parameter int SIZE_OF_WEIGHT  = 5,
  parameter int SIZE_OF_FEATURE = 2,
  parameter int PIX_WIDTH       = 8,
  parameter int STRIDE_MAX      = 2,
  parameter int MAX_CHNL        = 256,
  parameter int ACC_WIDTH       = 24,
  parameter int REG_WIDTH       = 32,
  parameter int N_PIX_OUT       = (SIZE_OF_FEATURE-1)*STRIDE_MAX+SIZE_OF_WEIGHT
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [REG_WIDTH-1:0]           i_param_cfg_stride,
  input  logic [REG_WIDTH-1:0]           i_param_cfg_chnl,
  input  logic [PIX_WIDTH*SIZE_OF_WEIGHT-1:0]  i_weight_col,
  input  logic [PIX_WIDTH*SIZE_OF_FEATURE-1:0] i_feature_map_col,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic                           en_prcs_new_chnl,
  output logic [ACC_WIDTH*N_PIX_OUT-1:0] o_cmpl_deconv_col,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_sat,
  output logic [$clog2(MAX_CHNL)-1:0]    o_chnl_idx
);
  localparam int K  = SIZE_OF_WEIGHT;
  localparam int F  = SIZE_OF_FEATURE;
  localparam int P  = PIX_WIDTH;
  localparam int A  = ACC_WIDTH;
  localparam int SB = $clog2(STRIDE_MAX+1);
  localparam int CW = $clog2(MAX_CHNL);
  // Headroom so one beat's lane sum plus the old accumulator never wraps before clipping.
  localparam int SW = A + $clog2(F+1) + 2;
  localparam logic signed [SW-1:0] SAT_HI = {{(SW-A+1){1'b0}}, {(A-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {{(SW-A+1){1'b1}}, {(A-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t              state, state_nx;
  logic [SB-1:0]       s_q, s_in, s_eff;
  logic [CW-1:0]       c_last_q, c_last_in, cnt_q;
  logic signed [A-1:0] acc_q  [N_PIX_OUT];
  logic signed [A-1:0] acc_nx [N_PIX_OUT];
  logic signed [2*P-1:0] prod;
  logic signed [SW-1:0]  lane, base, tot;
  logic sat_q, en_q, clip_any, accept, first, last_beat;

  assign o_ready          = (state != HOLD);
  assign o_valid          = (state == HOLD);
  assign accept           = i_valid && o_ready;
  assign first            = (state == IDLE);
  assign s_eff            = first ? s_in : s_q;
  assign last_beat        = first ? (c_last_in == '0) : (cnt_q == c_last_q);
  assign en_prcs_new_chnl = en_q;
  assign o_sat            = sat_q;
  assign o_chnl_idx       = cnt_q;

  always_comb begin
    if (i_param_cfg_stride == '0)                          s_in = SB'(1);
    else if (i_param_cfg_stride > REG_WIDTH'(STRIDE_MAX))  s_in = SB'(STRIDE_MAX);
    else                                                   s_in = SB'(i_param_cfg_stride);
    if (i_param_cfg_chnl == '0)                            c_last_in = '0;
    else if (i_param_cfg_chnl > REG_WIDTH'(MAX_CHNL))      c_last_in = CW'(MAX_CHNL-1);
    else                                                   c_last_in = CW'(i_param_cfg_chnl - REG_WIDTH'(1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nx = last_beat ? HOLD : ACCUM;
      HOLD:        if (i_ready) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  // Gather form of the overlap-add: lane j collects every (f,k) with f*S+k == j.
  always_comb begin
    clip_any = 1'b0;
    prod     = '0;
    lane     = '0;
    base     = '0;
    tot      = '0;
    acc_nx   = '{default: '0};
    for (int j = 0; j < N_PIX_OUT; j++) begin
      lane = '0;
      for (int f = 0; f < F; f++) begin
        for (int k = 0; k < K; k++) begin
          if (f*int'(s_eff) + k == j) begin
            prod = $signed(i_feature_map_col[f*P +: P]) * $signed(i_weight_col[k*P +: P]);
            lane = lane + {{(SW-2*P){prod[2*P-1]}}, prod};
          end
        end
      end
      base = first ? '0 : {{(SW-A){acc_q[j][A-1]}}, acc_q[j]};
      tot  = base + lane;
      if (tot > SAT_HI) begin
        acc_nx[j] = SAT_HI[A-1:0];
        clip_any  = 1'b1;
      end else if (tot < SAT_LO) begin
        acc_nx[j] = SAT_LO[A-1:0];
        clip_any  = 1'b1;
      end else begin
        acc_nx[j] = tot[A-1:0];
      end
    end
  end

  always_comb begin
    o_cmpl_deconv_col = '0;
    for (int j = 0; j < N_PIX_OUT; j++) o_cmpl_deconv_col[j*A +: A] = acc_q[j];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      s_q      <= SB'(1);
      c_last_q <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      en_q     <= 1'b0;
      acc_q    <= '{default: '0};
    end else begin
      state <= state_nx;
      en_q  <= accept && !last_beat;
      if (accept) begin
        acc_q <= acc_nx;
        sat_q <= (first ? 1'b0 : sat_q) | clip_any;
        if (first) begin
          s_q      <= s_in;
          c_last_q <= c_last_in;
          cnt_q    <= last_beat ? '0 : CW'(1);
        end else if (!last_beat) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (state == HOLD && i_ready) begin
        acc_q <= '{default: '0};
        sat_q <= 1'b0;
        cnt_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_deconv_col_accum.sv
// Bench for deconv_col_accum with K=3, F=2, S_MAX=2, 16-bit lanes: fixed vectors, corner sequences,
// and random groups against a scatter-style overlap-add model.
module tb_deconv_col_accum;
  localparam int K = 3, F = 2, P = 8, SM = 2, MC = 8, A = 16, R = 32;
  localparam int N = (F-1)*SM + K;
  localparam int CW = $clog2(MC);
  localparam int CB = N*A;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [R-1:0]  cfg_s, cfg_c;
  logic [P*K-1:0] wcol;
  logic [P*F-1:0] fcol;
  logic          i_valid, o_ready, en, o_valid, i_ready, o_sat;
  logic [CB-1:0] col;
  logic [CW-1:0] idx;

  int n_cmp = 0, n_bad = 0;
  int m_acc [N];
  bit m_sat;

  always #5 clk = ~clk;

  deconv_col_accum #(
    .SIZE_OF_WEIGHT(K), .SIZE_OF_FEATURE(F), .PIX_WIDTH(P), .STRIDE_MAX(SM),
    .MAX_CHNL(MC), .ACC_WIDTH(A), .REG_WIDTH(R)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_param_cfg_stride(cfg_s), .i_param_cfg_chnl(cfg_c),
    .i_weight_col(wcol), .i_feature_map_col(fcol), .i_valid(i_valid), .o_ready(o_ready),
    .en_prcs_new_chnl(en), .o_cmpl_deconv_col(col), .o_valid(o_valid), .i_ready(i_ready),
    .o_sat(o_sat), .o_chnl_idx(idx)
  );

  typedef struct {
    int s;
    int f0, f1, w0, w1, w2;
    logic [CB-1:0] exp_col;
  } vec_t;

  task automatic chk(input string nm, input logic [CB-1:0] act, input logic [CB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CB-1:0] pack5(input int a, input int b, input int c, input int d, input int e);
    return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [P*F-1:0] pk_f(input int a, input int b);
    return {8'(b), 8'(a)};
  endfunction

  function automatic logic [P*K-1:0] pk_w(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic int clamp_s(input int v);
    return (v == 0) ? 1 : ((v > SM) ? SM : v);
  endfunction

  function automatic int clamp_c(input int v);
    return (v == 0) ? 1 : ((v > MC) ? MC : v);
  endfunction

  // Overlap-add: scatter every product to f*S+k, then a saturating add into the running column.
  task automatic model_beat(input bit first, input int s, input int fv0, input int fv1,
                            input int wv0, input int wv1, input int wv2);
    int fv [F];
    int wv [K];
    int contrib [N];
    int t;
    fv = '{fv0, fv1};
    wv = '{wv0, wv1, wv2};
    foreach (contrib[j]) contrib[j] = 0;
    for (int f = 0; f < F; f++)
      for (int k = 0; k < K; k++)
        contrib[f*s + k] += fv[f] * wv[k];
    if (first) m_sat = 1'b0;
    for (int j = 0; j < N; j++) begin
      t = (first ? 0 : m_acc[j]) + contrib[j];
      if (t > 32767) begin t = 32767; m_sat = 1'b1; end
      if (t < -32768) begin t = -32768; m_sat = 1'b1; end
      m_acc[j] = t;
    end
  endtask

  function automatic logic [CB-1:0] model_col();
    return pack5(m_acc[0], m_acc[1], m_acc[2], m_acc[3], m_acc[4]);
  endfunction

  task automatic send_beat(input logic [P*F-1:0] fm, input logic [P*K-1:0] wc, input int s,
                           input int c, input bit exp_pulse, input string nm);
    i_valid = 1'b1;
    fcol    = fm;
    wcol    = wc;
    cfg_s   = R'(s);
    cfg_c   = R'(c);
    chk({nm, "_rdy"}, CB'(o_ready), CB'(1));
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    chk({nm, "_pulse"}, CB'(en), CB'(exp_pulse));
  endtask

  task automatic collect(input logic [CB-1:0] exp_col, input bit exp_sat, input int stall, input string nm);
    chk({nm, "_valid"}, CB'(o_valid), CB'(1));
    chk({nm, "_col"}, col, exp_col);
    chk({nm, "_sat"}, CB'(o_sat), CB'(exp_sat));
    for (int i = 0; i < stall; i++) begin
      i_valid = 1'b1;
      fcol    = P*F'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_stall_rdy"}, CB'(o_ready), CB'(0));
      chk({nm, "_stall_col"}, col, exp_col);
      chk({nm, "_stall_sat"}, CB'(o_sat), CB'(exp_sat));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    chk({nm, "_done_valid"}, CB'(o_valid), CB'(0));
    chk({nm, "_done_rdy"}, CB'(o_ready), CB'(1));
    chk({nm, "_done_col"}, col, CB'(0));
    chk({nm, "_done_idx"}, CB'(idx), CB'(0));
  endtask

  vec_t tbl [6];

  initial begin
    int s_raw, c_raw, s_grp, c_grp, f0, f1, w0, w1, w2;

    tbl[0] = '{2, 1, 2, 1, 1, 1, pack5(1, 1, 3, 2, 2)};
    tbl[1] = '{1, 1, 2, 1, 1, 1, pack5(1, 3, 3, 2, 0)};
    tbl[2] = '{0, 1, 2, 1, 1, 1, pack5(1, 3, 3, 2, 0)};
    tbl[3] = '{7, 1, 2, 1, 1, 1, pack5(1, 1, 3, 2, 2)};
    tbl[4] = '{2, -3, 4, 2, -1, 5, pack5(-6, 3, -7, -4, 20)};
    tbl[5] = '{1, -3, 4, 2, -1, 5, pack5(-6, 11, -19, 20, 0)};

    i_valid = 1'b0;
    i_ready = 1'b0;
    cfg_s   = R'(1);
    cfg_c   = R'(1);
    fcol    = '0;
    wcol    = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", CB'(o_ready), CB'(1));
    chk("rst_valid", CB'(o_valid), CB'(0));
    chk("rst_pulse", CB'(en), CB'(0));
    chk("rst_col", col, CB'(0));
    chk("rst_sat", CB'(o_sat), CB'(0));
    chk("rst_idx", CB'(idx), CB'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send_beat(pk_f(tbl[i].f0, tbl[i].f1), pk_w(tbl[i].w0, tbl[i].w1, tbl[i].w2),
                tbl[i].s, 1, 1'b0, "tbl");
      collect(tbl[i].exp_col, 1'b0, 0, "tbl");
    end

    // Two channels back to back; the second beat carries junk config that must be ignored.
    send_beat(pk_f(1, 2), pk_w(1, 1, 1), 2, 2, 1'b1, "c2_b0");
    chk("c2_idx", CB'(idx), CB'(1));
    send_beat(pk_f(1, 2), pk_w(1, 1, 1), 1, 1, 1'b0, "c2_b1");
    collect(pack5(2, 2, 6, 4, 4), 1'b0, 5, "c2");
    send_beat(pk_f(1, 2), pk_w(1, 1, 1), 2, 1, 1'b0, "fresh");
    collect(pack5(1, 1, 3, 2, 2), 1'b0, 0, "fresh");

    for (int b = 0; b < 4; b++)
      send_beat(pk_f(-128, -128), pk_w(-128, -128, -128), 2, 4, b != 3, "satg");
    collect(pack5(32767, 32767, 32767, 32767, 32767), 1'b1, 0, "satg");
    send_beat(pk_f(1, 2), pk_w(1, 1, 1), 2, 1, 1'b0, "post_sat");
    collect(pack5(1, 1, 3, 2, 2), 1'b0, 0, "post_sat");

    send_beat(pk_f(5, 6), pk_w(7, 8, 9), 2, 3, 1'b1, "mid_rst");
    rst_n = 1'b0;
    #1;
    chk("mrst_rdy", CB'(o_ready), CB'(1));
    chk("mrst_valid", CB'(o_valid), CB'(0));
    chk("mrst_pulse", CB'(en), CB'(0));
    chk("mrst_col", col, CB'(0));
    chk("mrst_sat", CB'(o_sat), CB'(0));
    chk("mrst_idx", CB'(idx), CB'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(pk_f(-3, 4), pk_w(2, -1, 5), 2, 1, 1'b0, "after_rst");
    collect(pack5(-6, 3, -7, -4, 20), 1'b0, 0, "after_rst");

    for (int g = 0; g < 40; g++) begin
      s_raw = int'($urandom_range(0, 4));
      c_raw = int'($urandom_range(0, 10));
      s_grp = clamp_s(s_raw);
      c_grp = clamp_c(c_raw);
      for (int b = 0; b < c_grp; b++) begin
        f0 = int'($urandom_range(0, 255)) - 128;
        f1 = int'($urandom_range(0, 255)) - 128;
        w0 = int'($urandom_range(0, 255)) - 128;
        w1 = int'($urandom_range(0, 255)) - 128;
        w2 = int'($urandom_range(0, 255)) - 128;
        model_beat(b == 0, s_grp, f0, f1, w0, w1, w2);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        if (b == 0)
          send_beat(pk_f(f0, f1), pk_w(w0, w1, w2), s_raw, c_raw, b != c_grp-1, "rnd");
        else
          send_beat(pk_f(f0, f1), pk_w(w0, w1, w2), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 10)), b != c_grp-1, "rnd");
      end
      collect(model_col(), m_sat, int'($urandom_range(0, 2)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
